// File: rtl/timer16_down_pkg.sv
// Shared types and default widths for the timing subsystem timers.
// Used by timer16_down, its prescaler and its bus interface.
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

   localparam int TIMER_WIDTH = 16;
   localparam int TIMER_PRE_W = 8;

endpackage

// File: rtl/timer16_down_if.sv
// Load handshake and status bundle for timer16_down.
// The periodic input exists only when TIMER16_AUTO_RELOAD_EN is defined.
interface timer16_down_if import timer_pkg::*; #(
   parameter int WIDTH = TIMER_WIDTH,
   parameter int PRE_W = TIMER_PRE_W
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic [PRE_W-1:0] prescale;
   logic             abort;
   logic             done_ack;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             expired;
   logic             done;
`ifdef TIMER16_AUTO_RELOAD_EN
   logic             periodic;
`endif

   modport master (
      output load_valid, load_value, prescale, abort, done_ack,
`ifdef TIMER16_AUTO_RELOAD_EN
      output periodic,
`endif
      input  load_ready, count, busy, expired, done
   );

   modport slave (
      input  load_valid, load_value, prescale, abort, done_ack,
`ifdef TIMER16_AUTO_RELOAD_EN
      input  periodic,
`endif
      output load_ready, count, busy, expired, done
   );

endinterface

// File: rtl/timer16_down_prescaler.sv
// Prescaler for timer16_down: counts 0..pre while enabled and flags a tick
// in the cycle where the count equals pre, then wraps back to 0.
module timer_prescaler import timer_pkg::*; #(
   parameter int PRE_W = TIMER_PRE_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [PRE_W-1:0] pre,
   input  logic             clr,
   input  logic             en,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_q;

   assign tick = en && (cnt_q == pre);

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + PRE_W'(1);
      end
   end

endmodule

// File: rtl/timer16_down.sv
// Loadable prescaled down-counting timer with terminal-count pulse and level.
// Optional auto-reload (periodic) mode is enabled by TIMER16_AUTO_RELOAD_EN.
module timer16_down import timer_pkg::*; #(
   parameter int WIDTH = TIMER_WIDTH,
   parameter int PRE_W = TIMER_PRE_W
) (
   input logic           clk,
   input logic           rstn,
   timer16_down_if.slave bus
);

   timer_state_t     state_q, state_n;
   logic [WIDTH-1:0] count_q, count_n;
   logic [WIDTH-1:0] reload_q;
   logic [PRE_W-1:0] pre_q;
   logic             expired_q, expired_n;
   logic             done_q, done_n;
   logic             busy_q, ready_q, ready_n;
   logic             zpend_q, zpend_n;
   logic             periodic_q;
   logic             accept, pre_clr, tick;

   assign accept = bus.load_valid && ready_q;

   timer_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk  (clk),
      .rstn (rstn),
      .pre  (pre_q),
      .clr  (pre_clr),
      .en   (state_q == RUN),
      .tick (tick)
   );

   // A zero load waits one cycle in IDLE (not ready, not busy) before DONE.
   always_comb begin
      state_n   = state_q;
      count_n   = count_q;
      expired_n = 1'b0;
      done_n    = done_q;
      zpend_n   = 1'b0;
      pre_clr   = accept;
      unique case (state_q)
         IDLE: begin
            if (zpend_q) begin
               state_n   = DONE;
               expired_n = 1'b1;
               done_n    = 1'b1;
            end else if (accept) begin
               count_n = bus.load_value;
               if (bus.load_value == '0) zpend_n = 1'b1;
               else                      state_n = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_n = IDLE;
               count_n = '0;
            end else if (tick) begin
               if (count_q > WIDTH'(1)) begin
                  count_n = count_q - WIDTH'(1);
               end else if (periodic_q) begin
                  count_n   = reload_q;
                  expired_n = 1'b1;
                  pre_clr   = 1'b1;
               end else begin
                  count_n   = '0;
                  expired_n = 1'b1;
                  done_n    = 1'b1;
                  state_n   = DONE;
               end
            end
         end
         DONE: begin
            if (bus.done_ack) begin
               state_n = IDLE;
               done_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
      ready_n = (state_n == IDLE) && !zpend_n;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q   <= IDLE;
         count_q   <= '0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         zpend_q   <= 1'b0;
      end else begin
         state_q   <= state_n;
         count_q   <= count_n;
         expired_q <= expired_n;
         done_q    <= done_n;
         busy_q    <= (state_n == RUN);
         ready_q   <= ready_n;
         zpend_q   <= zpend_n;
      end
   end

`ifdef TIMER16_AUTO_RELOAD_EN
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)        periodic_q <= 1'b0;
      else if (accept) periodic_q <= bus.periodic;
   end
`else
   assign periodic_q = 1'b0;
`endif

   // Reload value and prescale are plain data latched at an accepted load.
   always_ff @(posedge clk) begin
      if (accept) begin
         reload_q <= bus.load_value;
         pre_q    <= bus.prescale;
      end
   end

   assign bus.load_ready = ready_q;
   assign bus.count      = count_q;
   assign bus.busy       = busy_q;
   assign bus.expired    = expired_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_timer16_down.sv
// Randomised bench for timer16_down against a closed-form timing model.
// Build with TIMER16_AUTO_RELOAD_EN to also cover periodic mode.
module tb_timer16_down;
   import timer_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   timer16_down_if #(.WIDTH(16), .PRE_W(8)) bus();

   timer16_down #(.WIDTH(16), .PRE_W(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_valid = 1'b0;
      bus.load_value = '0;
      bus.prescale   = '0;
      bus.abort      = 1'b0;
      bus.done_ack   = 1'b0;
`ifdef TIMER16_AUTO_RELOAD_EN
      bus.periodic   = 1'b0;
`endif
   endtask

   task automatic chk_out(input string tag, input int c, input int b,
                          input int e, input int d, input int r);
      chk({tag, " count"},   int'(bus.count),      c);
      chk({tag, " busy"},    int'(bus.busy),       b);
      chk({tag, " expired"}, int'(bus.expired),    e);
      chk({tag, " done"},    int'(bus.done),       d);
      chk({tag, " ready"},   int'(bus.load_ready), r);
   endtask

   task automatic do_load(input int v, input int p, input int per);
      int i = 0;
      while (!bus.load_ready && i < 20) begin
         tick();
         i++;
      end
      chk("load_ready_wait", int'(bus.load_ready), 1);
      bus.load_valid = 1'b1;
      bus.load_value = v[15:0];
      bus.prescale   = p[7:0];
`ifdef TIMER16_AUTO_RELOAD_EN
      bus.periodic   = per[0];
`endif
      tick();
      bus.load_valid = 1'b0;
   endtask

   // k counts edges since the accepting edge; expectations are closed-form in k.
   task automatic run_txn(input int v, input int p, input int per,
                          input int abort_at, input int ack_wait);
      int    t;
      int    k = 0;
      int    dwait = 0;
      bit    fin = 0, aborted = 0, acked = 0, ab_n, ack_n, in_done, per_eff;
      int    ec, eb, ee, ed, er;
      string tag;
`ifdef TIMER16_AUTO_RELOAD_EN
      per_eff = (per != 0) && (v > 0);
`else
      per_eff = 0;
`endif
      t = v * (p + 1);
      do_load(v, p, per);
      while (!fin) begin
         tag = $sformatf("v%0d p%0d per%0d k%0d", v, p, per_eff, k);
         if (aborted || acked) begin
            ec = 0; eb = 0; ee = 0; ed = 0; er = 1; fin = 1;
         end else if (v == 0) begin
            ec = 0; eb = 0; ee = (k == 1); ed = (k >= 1); er = 0;
         end else if (per_eff) begin
            ec = v - (k % t) / (p + 1); eb = 1;
            ee = (k > 0) && (k % t == 0); ed = 0; er = 0;
         end else if (k < t) begin
            ec = v - k / (p + 1); eb = 1; ee = 0; ed = 0; er = 0;
         end else begin
            ec = 0; eb = 0; ee = (k == t); ed = 1; er = 0;
         end
         chk_out(tag, ec, eb, ee, ed, er);
         if (fin) begin
            idle_inputs();
         end else begin
            ab_n  = 0;
            ack_n = 0;
            in_done = !per_eff && ((v == 0) ? (k >= 1) : (k >= t));
            bus.abort    = 1'b0;
            bus.done_ack = 1'b0;
            if (in_done) begin
               dwait++;
               if (dwait > ack_wait) begin
                  bus.done_ack = 1'b1;
                  ack_n = 1;
               end
               bus.abort = 1'($urandom % 2);
            end else if (k == abort_at) begin
               bus.abort = 1'b1;
               ab_n = 1;
            end else begin
               bus.done_ack = 1'($urandom % 2);
            end
            bus.load_valid = 1'($urandom % 2);
            bus.load_value = 16'($urandom);
            bus.prescale   = 8'($urandom);
`ifdef TIMER16_AUTO_RELOAD_EN
            bus.periodic   = 1'($urandom % 2);
`endif
            tick();
            k++;
            aborted = ab_n;
            acked   = ack_n;
            if (k > 4000) begin
               chk({tag, " cycle_budget"}, k, 0);
               idle_inputs();
               fin = 1;
            end
         end
      end
   endtask

   initial begin
      int v, p, per, ab, t;
      idle_inputs();
      rstn = 1'b1;
      repeat (3) tick();
      chk_out("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rstn = 1'b0;
      tick();
      chk_out("post_reset", 0, 0, 0, 0, 1);

      run_txn(5, 0, 0, -1, 0);
      run_txn(3, 2, 0, -1, 1);
      run_txn(0, 1, 0, -1, 2);
      run_txn(4, 0, 0, 3, 0);
      run_txn(1, 0, 0, -1, 0);
      run_txn(2, 3, 0, 7, 0);

      // Asynchronous reset in the middle of a long run.
      do_load(32'h8000, 0, 0);
      chk("rst_run count0", int'(bus.count), 32'h8000);
      chk("rst_run busy", int'(bus.busy), 1);
      tick();
      chk("rst_run count1", int'(bus.count), 32'h7fff);
      #3 rstn = 1'b1;
      #1 chk_out("async_rst", 0, 0, 0, 0, 0);
      tick();
      chk_out("held_rst", 0, 0, 0, 0, 0);
      rstn = 1'b0;
      tick();
      chk_out("rst_release", 0, 0, 0, 0, 1);

`ifdef TIMER16_AUTO_RELOAD_EN
      run_txn(2, 1, 1, 12, 0);
      run_txn(0, 2, 1, -1, 0);
`endif

      for (int i = 0; i < 25; i++) begin
         v   = $urandom % 8;
         p   = $urandom % 4;
         per = $urandom % 2;
         t   = v * (p + 1);
`ifdef TIMER16_AUTO_RELOAD_EN
         if (per != 0 && v > 0) ab = $urandom_range(3 * t, t);
         else
`endif
         ab = (v > 0 && ($urandom % 3) == 0) ? int'($urandom % t) : -1;
         run_txn(v, p, per, ab, $urandom % 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
